// File: rtl/ecc_rd_pipe.sv
// Read-side ECC stage: two-stage elastic pipeline that corrects single-bit
// errors in each Hamming(7,4) codeword of a RAM word and tracks error status.
module ecc_rd_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned NIB    = DATA_W / 4,
    localparam int unsigned CODE_W = NIB * 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              parity_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [ID_W-1:0]   in_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic [NIB-1:0]    out_err_mask,
    output logic              out_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              err_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q;
    logic [ID_W-1:0]   s1_id_q;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q;
    logic [NIB-1:0]    s2_mask_q;
    logic [ID_W-1:0]   s2_id_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;

    logic              in_fire;
    logic              s2_load;
    logic [DATA_W-1:0] dec_data;
    logic [NIB-1:0]    dec_mask;
    logic [6:0]        cw;
    logic [2:0]        syn;

    // Handshake: stage 2 refills when empty or draining; stage 1 when it empties into stage 2
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !rst && (!s1_valid_q || s2_load);
    assign in_fire  = in_valid && in_ready;

    // Per-codeword syndrome, single-bit correction and payload extraction
    always_comb begin
        dec_data = '0;
        dec_mask = '0;
        cw       = '0;
        syn      = '0;
        for (int k = 0; k < NIB; k++) begin
            cw     = s1_code_q[7*k +: 7];
            syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ parity_type;
            syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ parity_type;
            syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ parity_type;
            if (syn != 3'd0) begin
                cw[syn - 3'd1] = ~cw[syn - 3'd1];
                dec_mask[k]    = 1'b1;
            end
            dec_data[4*k +: 4] = {cw[6], cw[5], cw[4], cw[2]};
        end
    end

    // Next-state for valid bits and status; clear wins over a same-cycle increment
    always_comb begin
        s1_valid_d = in_fire || (s1_valid_q && !s2_load);
        s2_valid_d = s2_load || (s2_valid_q && !out_ready);
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        if (err_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (s2_load && (dec_mask != '0)) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Pipeline and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mask_q  <= '0;
            s2_id_q    <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            if (in_fire) begin
                s1_code_q <= in_code;
                s1_id_q   <= in_id;
            end
            if (s2_load) begin
                s2_data_q <= dec_data;
                s2_mask_q <= dec_mask;
                s2_id_q   <= s1_id_q;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = s2_data_q;
    assign out_id       = s2_id_q;
    assign out_err_mask = s2_mask_q;
    assign out_err      = |s2_mask_q;
    assign err_count    = cnt_q;
    assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_ecc_rd_pipe.sv
// Bench for ecc_rd_pipe: vector table, scoreboard-checked output stream,
// backpressure, counter saturation/clear and mid-flight reset sequences.
module tb_ecc_rd_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NIB    = 8;
    localparam int unsigned CODE_W = 56;
    localparam int unsigned ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              parity_type;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic [ID_W-1:0]   in_id;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ID_W-1:0]   out_id;
    logic [NIB-1:0]    out_err_mask;
    logic              out_err;
    logic              err_sticky;
    logic [15:0]       err_count;
    logic              err_clr;

    // Second instance with a 2-bit counter shares all stimulus
    logic              sat_in_ready, sat_out_valid, sat_out_err, sat_err_sticky;
    logic [DATA_W-1:0] sat_out_data;
    logic [ID_W-1:0]   sat_out_id;
    logic [NIB-1:0]    sat_out_err_mask;
    logic [1:0]        sat_err_count;

    ecc_rd_pipe u_dut (
        .clk(clk), .rst(rst), .parity_type(parity_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .out_err_mask(out_err_mask), .out_err(out_err),
        .err_sticky(err_sticky), .err_count(err_count), .err_clr(err_clr)
    );

    ecc_rd_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .parity_type(parity_type),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_code(in_code), .in_id(in_id),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_id(sat_out_id),
        .out_err_mask(sat_out_err_mask), .out_err(sat_out_err),
        .err_sticky(sat_err_sticky), .err_count(sat_err_count), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              par;
        logic [CODE_W-1:0] code;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [NIB-1:0]    mask;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [NIB-1:0]    mask;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d, input logic p);
        logic [6:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6] ^ p;
        c[1] = c[2] ^ c[5] ^ c[6] ^ p;
        c[3] = c[4] ^ c[5] ^ c[6] ^ p;
        return c;
    endfunction

    // Scoreboard: every visible output beat must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check("out_data", 64'(out_data), 64'(sb[0].data));
                check("out_id", 64'(out_id), 64'(sb[0].id));
                check("out_err_mask", 64'(out_err_mask), 64'(sb[0].mask));
                check("out_err", 64'(out_err), 64'(sb[0].mask != '0));
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
    end

    // Drive one beat from posedge+1; expected result pushed at the accepting edge
    task automatic send(input logic [CODE_W-1:0] code, input logic [ID_W-1:0] id,
                        input logic [DATA_W-1:0] d, input logic [NIB-1:0] m);
        exp_t e;
        bit   done;
        bit   rdy;
        done     = 0;
        in_valid = 1'b1;
        in_code  = code;
        in_id    = id;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                e.data = d; e.id = id; e.mask = m;
                sb.push_back(e);
                done = 1;
            end
        end
        #1 in_valid = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_id"}, 64'(out_id), 64'd0);
        check({tag, "_out_err_mask"}, 64'(out_err_mask), 64'd0);
        check({tag, "_out_err"}, 64'(out_err), 64'd0);
        check({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs[7];
        logic [CODE_W-1:0] good, ebeat;
        logic [CODE_W-1:0] scode[8];
        logic [DATA_W-1:0] sdata[8];
        logic [NIB-1:0]    smask[8];
        bit                saw_stall;
        int                pop0;

        good  = {8{7'h55}};
        ebeat = good ^ (56'd1 << 16);
        vecs[0] = '{1'b0, good, 4'd3, 32'hBBBB_BBBB, 8'h00};
        vecs[1] = '{1'b0, ebeat, 4'd5, 32'hBBBB_BBBB, 8'h04};
        vecs[2] = '{1'b0, {8{7'h00}}, 4'd7, 32'h0000_0000, 8'h00};
        vecs[3] = '{1'b0, {8{7'h7F}}, 4'd8, 32'hFFFF_FFFF, 8'h00};
        vecs[4] = '{1'b0, good ^ 56'd1 ^ (56'd1 << 55), 4'd9, 32'hBBBB_BBBB, 8'h81};
        vecs[5] = '{1'b1, {8{7'h0B}}, 4'd1, 32'h0000_0000, 8'h00};
        vecs[6] = '{1'b1, {8{7'h00}}, 4'd2, 32'h8888_8888, 8'hFF};

        rst = 1'b1; in_valid = 1'b0; in_code = '0; in_id = '0;
        out_ready = 1'b1; err_clr = 1'b0; parity_type = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Two-cycle latency from handshake
        send(good, 4'd3, 32'hBBBB_BBBB, 8'h00);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        drain();

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].par != parity_type) begin
                drain();
                parity_type = vecs[i].par;
            end
            send(vecs[i].code, vecs[i].id, vecs[i].data, vecs[i].mask);
        end
        drain();
        check("table_err_count", 64'(err_count), 64'd3);
        check("table_err_sticky", 64'(err_sticky), 64'd1);
        parity_type = 1'b0;

        // Saturation on the 2-bit counter instance
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("clr_err_count", 64'(err_count), 64'd0);
        check("clr_err_sticky", 64'(err_sticky), 64'd0);
        for (int i = 0; i < 5; i++) send(ebeat, 4'(i), 32'hBBBB_BBBB, 8'h04);
        drain();
        check("main_count_5", 64'(err_count), 64'd5);
        check("sat_count_3", 64'(sat_err_count), 64'd3);
        check("sat_sticky", 64'(sat_err_sticky), 64'd1);

        // err_clr coincides with the 6th errored beat entering stage 2
        send(ebeat, 4'd6, 32'hBBBB_BBBB, 8'h04);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("clr_pri_count", 64'(err_count), 64'd0);
        check("clr_pri_sticky", 64'(err_sticky), 64'd0);
        check("clr_pri_sat_count", 64'(sat_err_count), 64'd0);
        check("clr_pri_sat_sticky", 64'(sat_err_sticky), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // 8-beat stream with a 4-cycle downstream stall
        for (int i = 0; i < 8; i++) begin
            sdata[i] = $urandom;
            smask[i] = '0;
            for (int k = 0; k < 8; k++) scode[i][7*k +: 7] = enc(sdata[i][4*k +: 4], 1'b0);
            if (i % 2 == 1) begin
                int k, b;
                k = $urandom_range(0, 7);
                b = $urandom_range(0, 6);
                scode[i][7*k + b] = ~scode[i][7*k + b];
                smask[i][k] = 1'b1;
            end
        end
        pop0 = n_pop;
        saw_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(scode[i], 4'(i), sdata[i], smask[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!in_ready) saw_stall = 1;
                end
            end
        join
        drain();
        check("stream_in_ready_fell", 64'(saw_stall), 64'd1);
        check("stream_beats_out", 64'(n_pop - pop0), 64'd8);

        // Reset with two beats in flight
        send(ebeat, 4'd10, 32'hBBBB_BBBB, 8'h04);
        send(good, 4'd11, 32'hBBBB_BBBB, 8'h00);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(good ^ (56'd1 << 30), 4'd12, 32'hBBBB_BBBB, 8'h10);
        @(negedge clk);
        check("post_rst_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("post_rst_lat2", 64'(out_valid), 64'd1);
        drain();
        check("post_rst_count", 64'(err_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_rd_pipe.md
Name: ecc_rd_pipe

Overview:
- Read-side ECC stage between the RAM read port and the AXI read-data channel.
- Accepts one raw RAM word per beat, made of NIB Hamming(7,4) codewords. Corrects single-bit errors per codeword and returns the DATA_W-bit payload with per-nibble error flags.
- Elastic 2-stage pipeline with valid/ready on both sides. Keeps a saturating corrected-error counter and a sticky error flag for status registers.

Parameters:
- DATA_W, 32, payload width; must be a multiple of 4.
- NIB, DATA_W/4, number of codewords per word (derived; do not override).
- CODE_W, NIB*7, raw codeword width (derived).
- ID_W, 4, width of the sideband tag carried alongside the data.
- CNT_W, 16, width of the corrected-error counter.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- parity_type  input  1  0 = even, 1 = odd Hamming parity; quasi-static, change only while idle
- in_valid  input  1  RAM read beat valid
- in_ready  output  1  stage can accept a beat
- in_code  input  CODE_W  codeword k occupies in_code[7k+6:7k]; in_code[7k] is code bit 1, in_code[7k+6] is code bit 7
- in_id  input  ID_W  tag for the beat (AXI ID/last, etc.)
- out_valid  output  1  decoded beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  DATA_W  nibble k = out_data[4k+3:4k]
- out_id  output  ID_W  tag of the beat on out_data
- out_err_mask  output  NIB  bit k set = codeword k had a non-zero syndrome and was corrected
- out_err  output  1  OR of out_err_mask
- err_sticky  output  1  set by any errored beat entering stage 2
- err_count  output  CNT_W  count of errored beats, saturating
- err_clr  input  1  clears err_count and err_sticky

Behaviour:
- Stage 1 registers in_code/in_id; stage 2 registers decoded data, mask and id. Outputs are driven directly from stage 2 registers.
- Decode per codeword c[7:1], combinational between S1 and S2:
  - s1 = c1^c3^c5^c7^parity_type
  - s2 = c2^c3^c6^c7^parity_type
  - s3 = c4^c5^c6^c7^parity_type
  - pos = {s3,s2,s1}; if pos != 0, invert c[pos] and set the mask bit.
  - Data nibble = {c7,c6,c5,c3}.
- SEC only: double errors miscorrect silently. This is defined behaviour; no detection is required.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational through out_ready).
  - out_valid/out_data/out_id/out_err_mask stay stable while out_valid && !out_ready.
- Latency: 2 cycles from in handshake to out_valid with out_ready held high. Throughput: 1 beat/cycle sustained. No bubbles are inserted under backpressure release.
- Counter: on s2_load with any mask bit set, err_count += 1, saturating at 2^CNT_W-1 (no wrap). err_sticky is set on the same event.
- err_clr has priority over a simultaneous increment: the result is 0 / sticky 0 that cycle.
- Reset values: all valid bits 0, in_ready 0 during rst, out_data 0, out_id 0, out_err_mask 0, out_err 0, err_sticky 0, err_count 0. In-flight beats are discarded; in_ready returns to 1 the cycle after rst deasserts.
- Reset mid-operation: no partial beat may appear after reset; out_valid is 0 until a fresh beat traverses both stages.
- No combinational path from in_valid/in_code to any output.

Test Plan:
- Even parity, in_code = all codewords 7'h55, id 3 -> out_data 0xBBBBBBBB, out_id 3, out_err_mask 0x00, out_valid exactly 2 cycles after the handshake.
- Same beat with in_code bit 16 flipped (codeword 2, bit c3) -> out_data 0xBBBBBBBB, out_err_mask 0x04, out_err 1, err_count 1, err_sticky 1.
- Odd parity, every codeword 7'h0B -> out_data 0x00000000, mask 0. Every codeword 7'h00 with odd parity -> c7 flipped, out_data 0x88888888, mask 0xFF.
- Stream 8 back-to-back beats with out_ready low for cycles 3-6 -> in_ready falls once both stages are full. All 8 beats emerge in order with no loss or duplication, and outputs are held stable during the stall.
- CNT_W forced to 2: 5 errored beats -> err_count saturates at 3. err_clr on the same cycle as a 6th errored beat -> err_count 0, err_sticky 0.
- Assert rst with 2 beats in flight -> out_valid 0 from the next cycle, all outputs at reset values. Beats sent after reset decode correctly with 2-cycle latency.
